// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
// Combinational instruction memory is addressed by PC and its word is captured on the advancing edge.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_0400,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemInstr,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPcPlus4,
    output logic        IfIdValid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    fetch_state_t state_r;
    fetch_state_t state_s;

    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_instr_s;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_pc4_s;
    logic        ifid_valid_r;
    logic        ifid_valid_s;
    logic [31:0] fetch_count_r;
    logic [31:0] fetch_count_s;

    logic [31:0] pc_plus4_s;
    logic        in_range_s;
    logic [31:0] redirect_pc_s;

    assign pc_plus4_s    = pc_r + 32'd4;
    assign in_range_s    = (pc_r < IMEM_BYTES);
    // Redirect targets are forced to word alignment.
    assign redirect_pc_s = BranchTarget & ~32'h0000_0003;

    // Next-state and next-register selection; redirect dominates halt, halt dominates stall.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        ifid_instr_s  = ifid_instr_r;
        ifid_pc4_s    = ifid_pc4_r;
        ifid_valid_s  = ifid_valid_r;
        fetch_count_s = fetch_count_r;

        if (BranchTaken) begin
            state_s      = RUN;
            pc_s         = redirect_pc_s;
            ifid_instr_s = NOP_WORD;
            ifid_pc4_s   = 32'h0000_0000;
            ifid_valid_s = 1'b0;
        end else begin
            case (state_r)
                HALT: begin
                    ifid_instr_s = NOP_WORD;
                    ifid_pc4_s   = 32'h0000_0000;
                    ifid_valid_s = 1'b0;
                end
                RUN: begin
                    if (Stall) begin
                        state_s = RUN;
                    end else if (in_range_s) begin
                        pc_s          = pc_plus4_s;
                        ifid_instr_s  = ImemInstr;
                        ifid_pc4_s    = pc_plus4_s;
                        ifid_valid_s  = 1'b1;
                        fetch_count_s = fetch_count_r + 32'd1;
                    end else begin
                        state_s      = HALT;
                        ifid_instr_s = NOP_WORD;
                        ifid_pc4_s   = 32'h0000_0000;
                        ifid_valid_s = 1'b0;
                    end
                end
                default: begin
                    state_s      = HALT;
                    ifid_instr_s = NOP_WORD;
                    ifid_pc4_s   = 32'h0000_0000;
                    ifid_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC, IF/ID and fetch counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            ifid_instr_r  <= NOP_WORD;
            ifid_pc4_r    <= 32'h0000_0000;
            ifid_valid_r  <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            ifid_instr_r  <= ifid_instr_s;
            ifid_pc4_r    <= ifid_pc4_s;
            ifid_valid_r  <= ifid_valid_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    assign ImemAddr    = pc_r;
    assign IfIdInstr   = ifid_instr_r;
    assign IfIdPcPlus4 = ifid_pc4_r;
    assign IfIdValid   = ifid_valid_r;
    assign Halted      = (state_r == HALT);
    assign FetchCount  = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a short-memory instance (0x1C bytes) and a default-size
// instance (0x400 bytes) share stimulus; each sees a memory whose word encodes its address.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] a_imem_addr, a_imem_instr, a_instr, a_pc4, a_count;
    logic        a_valid, a_halted;
    logic [31:0] b_imem_addr, b_imem_instr, b_instr, b_pc4, b_count;
    logic        b_valid, b_halted;

    int vec_cnt;
    int err_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hA5C3, addr[15:0]};
    endfunction

    assign a_imem_instr = mem_word(a_imem_addr);
    assign b_imem_instr = mem_word(b_imem_addr);

    fetch_stage #(.IMEM_BYTES(32'h0000_001C)) dut_a (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .BranchTaken(branch_taken),
        .BranchTarget(branch_target), .ImemAddr(a_imem_addr), .ImemInstr(a_imem_instr),
        .IfIdInstr(a_instr), .IfIdPcPlus4(a_pc4), .IfIdValid(a_valid),
        .Halted(a_halted), .FetchCount(a_count)
    );

    fetch_stage dut_b (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .BranchTaken(branch_taken),
        .BranchTarget(branch_target), .ImemAddr(b_imem_addr), .ImemInstr(b_imem_instr),
        .IfIdInstr(b_instr), .IfIdPcPlus4(b_pc4), .IfIdValid(b_valid),
        .Halted(b_halted), .FetchCount(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, " addr"},   a_imem_addr, 32'h0000_0000);
        check_eq({tag, " instr"},  a_instr,     32'h0000_0000);
        check_eq({tag, " pc4"},    a_pc4,       32'h0000_0000);
        check_eq({tag, " valid"},  {31'd0, a_valid},  32'd0);
        check_eq({tag, " halted"}, {31'd0, a_halted}, 32'd0);
        check_eq({tag, " count"},  a_count,     32'd0);
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0000_0000;

        // Reset values, then free-run through the 7-word memory
        #12;
        check_reset_a("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq($sformatf("run%0d pc4", i), a_pc4, 32'(4 * i));
            check_eq($sformatf("run%0d instr", i), a_instr, mem_word(32'(4 * (i - 1))));
        end
        check_eq("run count", a_count, 32'd7);
        check_eq("run addr", a_imem_addr, 32'h0000_001C);

        // Out-of-range fetch halts, PC freezes, nothing counted
        tick();
        check_eq("halt halted", {31'd0, a_halted}, 32'd1);
        check_eq("halt valid", {31'd0, a_valid}, 32'd0);
        check_eq("halt addr", a_imem_addr, 32'h0000_001C);
        check_eq("halt count", a_count, 32'd7);
        tick();
        check_eq("halt2 addr", a_imem_addr, 32'h0000_001C);
        check_eq("halt2 pc4", a_pc4, 32'h0000_0000);

        // Redirect out of halt
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0000;
        tick();
        branch_taken = 1'b0;
        check_eq("resume halted", {31'd0, a_halted}, 32'd0);
        check_eq("resume addr", a_imem_addr, 32'h0000_0000);
        check_eq("resume valid", {31'd0, a_valid}, 32'd0);
        tick();
        check_eq("resume pc4", a_pc4, 32'h0000_0004);
        check_eq("resume instr", a_instr, mem_word(32'h0000_0000));
        check_eq("resume count", a_count, 32'd8);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("pre-rst count", a_count, 32'd5);
        check_eq("pre-rst valid", {31'd0, a_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_a("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Stall at PC=0x08 holds everything
        tick();
        tick();
        check_eq("prestall addr", a_imem_addr, 32'h0000_0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("stall%0d addr", i), a_imem_addr, 32'h0000_0008);
            check_eq($sformatf("stall%0d instr", i), a_instr, mem_word(32'h0000_0004));
            check_eq($sformatf("stall%0d valid", i), {31'd0, a_valid}, 32'd1);
            check_eq($sformatf("stall%0d count", i), a_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        check_eq("unstall pc4", a_pc4, 32'h0000_000C);
        check_eq("unstall count", a_count, 32'd3);
        tick();
        check_eq("prebr addr", a_imem_addr, 32'h0000_0010);

        // Redirect with simultaneous stall; unaligned target
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0015;
        stall         = 1'b1;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check_eq("br addr", a_imem_addr, 32'h0000_0014);
        check_eq("br valid", {31'd0, a_valid}, 32'd0);
        check_eq("br count", a_count, 32'd4);
        tick();
        check_eq("br pc4", a_pc4, 32'h0000_0018);
        check_eq("br instr", a_instr, mem_word(32'h0000_0014));
        check_eq("br count2", a_count, 32'd5);
        check_eq("b sync count", b_count, 32'd5);

        // Default-size instance: redirect exactly to the end of mapped space
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0400;
        tick();
        branch_taken = 1'b0;
        check_eq("edge halted0", {31'd0, b_halted}, 32'd0);
        check_eq("edge addr", b_imem_addr, 32'h0000_0400);
        check_eq("edge valid0", {31'd0, b_valid}, 32'd0);
        tick();
        check_eq("edge halted1", {31'd0, b_halted}, 32'd1);
        check_eq("edge valid1", {31'd0, b_valid}, 32'd0);
        check_eq("edge count", b_count, 32'd5);
        tick();
        check_eq("edge addr2", b_imem_addr, 32'h0000_0400);
        check_eq("edge valid2", {31'd0, b_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
